// File: rtl/uart_msg_loader.sv
// UART frame loader: collects an A5/LEN/payload frame into a 512-bit block and starts the hash core.
// Optional inter-byte timeout in LEN/PAYLOAD is enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_msg_loader #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready,
  input  logic         core_done,
  output logic [511:0] blk_data,
  output logic [6:0]   blk_len,
  output logic         core_start,
  output logic         busy,
  output logic         frame_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEN       = 3'd1;
  localparam logic [2:0] S_PAYLOAD   = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] MAX_LEN  = 8'd64;

  logic [2:0] state_reg;
  logic       rx_ready_reg;
  logic [5:0] idx_reg;
  logic [6:0] blk_len_reg;
  logic       core_start_reg;
  logic       busy_reg;
  logic       frame_err_reg;

  logic byte_evt;
  logic sof_accept;
  logic len_ok;
  logic last_byte;
  logic lane_wr;
  logic in_rx_phase;
  logic tmo_hit;

  // A byte counts only on the rising edge of the receiver's ready level.
  assign byte_evt    = rx_ready & ~rx_ready_reg;
  assign sof_accept  = (state_reg == S_IDLE) && byte_evt && (rx_data == SOF_BYTE);
  assign len_ok      = (rx_data != 8'd0) && (rx_data <= MAX_LEN);
  assign last_byte   = (({1'b0, idx_reg} + 7'd1) == blk_len_reg);
  assign lane_wr     = (state_reg == S_PAYLOAD) && byte_evt;
  assign in_rx_phase = (state_reg == S_LEN) || (state_reg == S_PAYLOAD);

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_reg;

  // A byte event on the expiry cycle wins over the timeout.
  assign tmo_hit = in_rx_phase && !byte_evt && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (!in_rx_phase || byte_evt) begin
      tmo_cnt_reg <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      rx_ready_reg   <= 1'b0;
      idx_reg        <= '0;
      blk_len_reg    <= '0;
      core_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_ready_reg   <= rx_ready;
      core_start_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (sof_accept) begin
            state_reg <= S_LEN;
            busy_reg  <= 1'b1;
          end
        end
        S_LEN: begin
          if (byte_evt) begin
            if (len_ok) begin
              blk_len_reg <= rx_data[6:0];
              idx_reg     <= '0;
              state_reg   <= S_PAYLOAD;
            end else begin
              frame_err_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= S_IDLE;
            end
          end else if (tmo_hit) begin
            frame_err_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (byte_evt) begin
            idx_reg <= idx_reg + 1'b1;
            if (last_byte) begin
              // core_start is registered so it coincides exactly with the START state.
              core_start_reg <= 1'b1;
              state_reg      <= S_START;
            end
          end else if (tmo_hit) begin
            frame_err_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        S_START: begin
          state_reg <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (byte_evt) begin
            frame_err_reg <= 1'b1;
          end
          if (core_done) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // One register per block byte; a new SOF wipes the whole block so unused bytes read zero.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (sof_accept) begin
          lane_reg <= '0;
        end else if (lane_wr && (idx_reg == 6'(gi))) begin
          lane_reg <= rx_data;
        end
      end

      assign blk_data[511 - 8*gi -: 8] = lane_reg;
    end
  endgenerate

  assign blk_len    = blk_len_reg;
  assign core_start = core_start_reg;
  assign busy       = busy_reg;
  assign frame_err  = frame_err_reg;

endmodule
